// File: rtl/mor1kx_wb_pkg.sv
// Shared Wishbone B3 constants for the mor1kx bus endpoints: cycle type
// identifiers, burst type extensions and the slave memory FSM encoding.
package mor1kx_wb_pkg;

    // Cycle type identifier (wbs_cti_i)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extension (wbs_bte_i)
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Slave memory FSM encoding
    typedef logic [1:0] wb_state_t;
    localparam wb_state_t ST_IDLE   = 2'd0;  // ready for a new request
    localparam wb_state_t ST_SINGLE = 2'd1;  // single access issued, ack pending
    localparam wb_state_t ST_BURST  = 2'd2;  // read burst streaming
    localparam wb_state_t ST_ERR    = 2'd3;  // error acknowledge pending

endpackage

// File: rtl/mor1kx_wb_adr_wrap.sv
// Next-beat word address for Wishbone bursts. Wrapping bursts increment only
// the low 2/3/4 index bits; linear bursts increment the whole index modulo
// 2^AW and report the carry out of the top bit, so the caller can tell a
// burst that ran off the end of the address space from a genuine wrap.
module mor1kx_wb_adr_wrap
    import mor1kx_wb_pkg::*;
#(
    parameter int AW = 10
)
(
    input  logic [AW-1:0] i_adr,
    input  logic [1:0]    i_bte,
    output logic [AW-1:0] o_adr,
    output logic          o_carry
);

    logic [AW:0]   w_inc;
    logic [AW-1:0] w_mask;

    assign w_inc = {1'b0, i_adr} + {{AW{1'b0}}, 1'b1};

    // Select the index bits that take part in the increment for this burst type.
    always_comb begin
        case (i_bte)
            BTE_WRAP4:  w_mask = AW'(3);
            BTE_WRAP8:  w_mask = AW'(7);
            BTE_WRAP16: w_mask = AW'(15);
            default:    w_mask = '1;
        endcase
    end

    assign o_adr   = (i_adr & ~w_mask) | (w_inc[AW-1:0] & w_mask);
    assign o_carry = (i_bte == BTE_LINEAR) & w_inc[AW];

endmodule

// File: rtl/mor1kx_wb32_slave_mem.sv
// Wishbone B3 32-bit slave in front of a synchronous single-port word memory
// with 1-cycle read latency. Classic accesses take two cycles; incrementing
// read bursts stream one beat per cycle by prefetching the next beat address
// while the current one is acknowledged.
module mor1kx_wb32_slave_mem
    import mor1kx_wb_pkg::*;
#(
    parameter int AW        = 10,
    parameter int MEM_WORDS = 1024
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic          wbs_we_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic [2:0]    wbs_cti_i,
    input  logic [1:0]    wbs_bte_i,
    output logic [31:0]   wbs_dat_o,
    output logic          wbs_ack_o,
    output logic          wbs_err_o,
    output logic          wbs_rty_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [3:0]    mem_bsel_o,
    output logic [31:0]   mem_dat_o,
    input  logic [31:0]   mem_dat_i
);

    localparam logic [AW:0] LP_MEM_WORDS = (AW+1)'(MEM_WORDS);

    // Registered state
    wb_state_t     r_state;
    logic [AW-1:0] r_cur;       // word index whose data is on mem_dat_i in BURST
    logic [AW-1:0] r_nxt;       // word index to prefetch on the next beat
    logic [1:0]    r_bte;
    logic          r_we;        // current single access is a write
    logic          r_nxt_oor;   // r_nxt lies outside the implemented memory

    // Combinational decode
    wb_state_t     w_state_nxt;
    logic          w_req;
    logic [AW-1:0] w_word;
    logic          w_adr_oor;
    logic          w_adr_match;
    logic          w_eob;
    logic [AW-1:0] w_wrap_in;
    logic [1:0]    w_wrap_bte;
    logic [AW-1:0] w_wrap_adr;
    logic          w_wrap_carry;
    logic          w_wrap_oor;
    logic          w_ack;
    logic          w_err;
    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_adr;
    logic          w_unused_adr;

    assign w_req        = wbs_cyc_i & wbs_stb_i;
    assign w_word       = wbs_adr_i[AW+1:2];
    assign w_adr_oor    = {1'b0, w_word} >= LP_MEM_WORDS;
    assign w_adr_match  = (w_word == r_cur);
    assign w_eob        = (wbs_cti_i == CTI_EOB);
    assign w_unused_adr = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

    // One address stepper serves both burst start (from the bus) and every
    // subsequent prefetch (from the latched next address).
    assign w_wrap_in  = (r_state == ST_IDLE) ? w_word    : r_nxt;
    assign w_wrap_bte = (r_state == ST_IDLE) ? wbs_bte_i : r_bte;

    mor1kx_wb_adr_wrap #(
        .AW      (AW)
    ) u_adr_wrap (
        .i_adr   (w_wrap_in),
        .i_bte   (w_wrap_bte),
        .o_adr   (w_wrap_adr),
        .o_carry (w_wrap_carry)
    );

    // A linear burst carrying out of the top index bit has run past the end
    // of memory, so it is treated as out of range rather than wrapping to 0.
    assign w_wrap_oor = w_wrap_carry | ({1'b0, w_wrap_adr} >= LP_MEM_WORDS);

    // Next-state, acknowledge and memory-strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_adr   = w_word;
        if (!wbs_cyc_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_adr_oor) begin
                            w_state_nxt = ST_ERR;
                        end else begin
                            w_mem_en = 1'b1;
                            w_mem_we = wbs_we_i;
                            if (!wbs_we_i && (wbs_cti_i == CTI_INCR))
                                w_state_nxt = ST_BURST;
                            else
                                w_state_nxt = ST_SINGLE;
                        end
                    end
                end
                ST_SINGLE: begin
                    w_ack       = w_req;
                    w_state_nxt = ST_IDLE;
                end
                ST_ERR: begin
                    w_err       = w_req;
                    w_state_nxt = ST_IDLE;
                end
                ST_BURST: begin
                    // Abort, address mismatch and end-of-burst all fall back
                    // to IDLE; only an ongoing matched beat keeps streaming.
                    w_state_nxt = ST_IDLE;
                    if (w_req && w_adr_match) begin
                        w_ack = 1'b1;
                        if (!w_eob) begin
                            if (r_nxt_oor) begin
                                w_state_nxt = ST_ERR;
                            end else begin
                                w_mem_en    = 1'b1;
                                w_mem_adr   = r_nxt;
                                w_state_nxt = ST_BURST;
                            end
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and burst address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cur     <= '0;
            r_nxt     <= '0;
            r_bte     <= BTE_LINEAR;
            r_we      <= 1'b0;
            r_nxt_oor <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_mem_en) begin
                r_we      <= wbs_we_i;
                r_cur     <= w_word;
                r_nxt     <= w_wrap_adr;
                r_bte     <= wbs_bte_i;
                r_nxt_oor <= w_wrap_oor;
            end else if ((r_state == ST_BURST) && w_mem_en) begin
                r_cur     <= r_nxt;
                r_nxt     <= w_wrap_adr;
                r_nxt_oor <= w_wrap_oor;
            end
        end
    end

    // Memory strobes are gated by reset so they drop as soon as reset asserts.
    assign mem_en_o   = w_mem_en & rst_n;
    assign mem_we_o   = w_mem_we & rst_n;
    assign mem_adr_o  = w_mem_adr;
    assign mem_bsel_o = wbs_sel_i;
    assign mem_dat_o  = wbs_dat_i;

    assign wbs_ack_o  = w_ack;
    assign wbs_err_o  = w_err;
    assign wbs_rty_o  = 1'b0;
    assign wbs_dat_o  = (w_ack && !r_we) ? mem_dat_i : 32'd0;

endmodule

// File: tb/tb_mor1kx_wb32_slave_mem.sv
// Bench for mor1kx_wb32_slave_mem: behavioural word memory on the mem_* side,
// table of classic accesses, hand sequences for bursts, abort, mismatch and
// reset, with a queue of expected acknowledges checked as they appear.
module tb_mor1kx_wb32_slave_mem;
    import mor1kx_wb_pkg::*;

    localparam int AW        = 10;
    localparam int MEM_WORDS = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic [3:0]    wbs_sel_i;
    logic          wbs_we_i;
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic [2:0]    wbs_cti_i;
    logic [1:0]    wbs_bte_i;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o;
    logic          wbs_err_o;
    logic          wbs_rty_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_adr_o;
    logic [3:0]    mem_bsel_o;
    logic [31:0]   mem_dat_o;
    logic [31:0]   mem_dat_i;

    always #5 clk = ~clk;

    mor1kx_wb32_slave_mem #(
        .AW        (AW),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cti_i  (wbs_cti_i),
        .wbs_bte_i  (wbs_bte_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_err_o  (wbs_err_o),
        .wbs_rty_o  (wbs_rty_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_adr_o  (mem_adr_o),
        .mem_bsel_o (mem_bsel_o),
        .mem_dat_o  (mem_dat_o),
        .mem_dat_i  (mem_dat_i)
    );

    function automatic logic [31:0] pat(input int i);
        logic [9:0] a;
        a = i[9:0];
        return {6'h16, a, 6'h2B, ~a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Behavioural synchronous memory with registered read
    logic [31:0] mem [0:MEM_WORDS-1];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] <= pat(i);
        mem[4]    <= 32'hDEADBEEF;
        mem_dat_i <= 32'd0;
        forever begin
            @(posedge clk);
            if (mem_en_o) begin
                if (mem_we_o) mem[mem_adr_o] <= merge(mem[mem_adr_o], mem_dat_o, mem_bsel_o);
                else          mem_dat_i      <= mem[mem_adr_o];
            end
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [31:0] exp;
    } vec_t;

    int          total;
    int          bad;
    int          n_ack;
    int          n_err;
    int          n_men;
    exp_t        sb[$];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Sample at the falling edge and match any acknowledge against the queue.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        check("ack_err_excl", 32'(wbs_ack_o & wbs_err_o), 32'd0);
        if (mem_en_o)  n_men++;
        if (wbs_ack_o) n_ack++;
        if (wbs_err_o) n_err++;
        if (wbs_ack_o || wbs_err_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: ack=%0b err=%0b dat=%h, none expected",
                         wbs_ack_o, wbs_err_o, wbs_dat_o);
            end else begin
                e = sb.pop_front();
                check("sb_err", 32'(wbs_err_o), 32'(e.err));
                check("sb_dat", wbs_dat_o, e.dat);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        wbs_cti_i = cti;
        wbs_bte_i = bte;
    endtask

    task automatic bus_idle();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'd0;
        wbs_dat_i = 32'd0;
        wbs_sel_i = 4'h0;
        wbs_cti_i = CTI_CLASSIC;
        wbs_bte_i = BTE_LINEAR;
    endtask

    task automatic push_rd(input int word);
        sb.push_back('{err: 1'b0, dat: ref_mem[word]});
    endtask

    // Classic access: strobe cycle issues the memory access, ack one cycle later.
    task automatic classic(input vec_t v);
        int            a0;
        logic [AW-1:0] w;
        w = v.adr[AW+1:2];
        drive(v.we, v.adr, v.dat, v.sel, v.cti, BTE_LINEAR);
        sample();
        check("cl_mem_en", 32'(mem_en_o), 32'd1);
        check("cl_mem_we", 32'(mem_we_o), 32'(v.we));
        check("cl_mem_adr", 32'(mem_adr_o), 32'(w));
        check("cl_early_ack", 32'(wbs_ack_o), 32'd0);
        sb.push_back('{err: 1'b0, dat: (v.we ? 32'd0 : v.exp)});
        advance();
        a0 = n_ack;
        sample();
        check("cl_ack_cnt", 32'(n_ack - a0), 32'd1);
        check("cl_no_reaccept", 32'(mem_en_o), 32'd0);
        if (v.we) begin
            check("cl_wr_mem", mem[w], v.exp);
            ref_mem[w] = v.exp;
        end
        advance();
        bus_idle();
        check("cl_sb_left", 32'(sb.size()), 32'd0);
        $display("txn classic we=%0b adr=%h dat_o/exp=%h", v.we, v.adr, v.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        vec_t cr;
        int   a0;
        int   e0;
        int   m0;
        int   order [8];

        total = 0;
        bad   = 0;
        n_ack = 0;
        n_err = 0;
        n_men = 0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i);
        ref_mem[4] = 32'hDEADBEEF;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,    CTI_CLASSIC, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 32'h0000_0008, 32'h11223344,  4'b0100, CTI_CLASSIC,
                    merge(pat(2), 32'h11223344, 4'b0100)};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         4'hF,    CTI_EOB,
                    merge(pat(2), 32'h11223344, 4'b0100)};
        vecs[3] = '{1'b1, 32'hABCD_0FFC, 32'h000000EE,  4'b0001, CTI_CLASSIC,
                    merge(pat(1023), 32'h000000EE, 4'b0001)};
        vecs[4] = '{1'b0, 32'h0000_0FFF, 32'h0,         4'hF,    CTI_CLASSIC,
                    merge(pat(1023), 32'h000000EE, 4'b0001)};
        vecs[5] = '{1'b1, 32'h0000_000C, 32'hCAFEF00D,  4'hF,    CTI_CLASSIC, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 32'h0000_000C, 32'h0,         4'hF,    CTI_CLASSIC, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 32'h0000_0030, 32'h0BADC0DE,  4'hF,    CTI_INCR,    32'h0BADC0DE};
        vecs[8] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF,    CTI_CLASSIC, pat(0)};

        // Reset with a request pending: nothing may reach the memory or the bus.
        rst_n = 1'b0;
        drive(1'b0, 32'h10, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        @(negedge clk);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_err", 32'(wbs_err_o), 32'd0);
        check("rst_mem_en", 32'(mem_en_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_rty", 32'(wbs_rty_o), 32'd0);
        advance();
        bus_idle();
        advance();
        rst_n = 1'b1;
        advance();

        // Classic accesses from the table.
        for (int i = 0; i < 9; i++) classic(vecs[i]);

        // Wrap8 burst from 0x14: words 5,6,7,0,1,2,3,4 on consecutive cycles.
        order = '{5, 6, 7, 0, 1, 2, 3, 4};
        drive(1'b0, 32'h14, 32'h0, 4'hF, CTI_INCR, BTE_WRAP8);
        sample();
        check("w8_start_en", 32'(mem_en_o), 32'd1);
        advance();
        a0 = n_ack;
        for (int b = 0; b < 8; b++) begin
            drive(1'b0, 32'(order[b] * 4), 32'h0, 4'hF, (b == 7) ? CTI_EOB : CTI_INCR, BTE_WRAP8);
            push_rd(order[b]);
            sample();
            check("w8_beat_ack", 32'(wbs_ack_o), 32'd1);
            advance();
        end
        check("w8_ack_cnt", 32'(n_ack - a0), 32'd8);
        $display("txn wrap8 burst from 0x14, %0d beats", n_ack - a0);
        cr = '{1'b0, 32'h50, 32'h0, 4'hF, CTI_CLASSIC, pat(20)};
        classic(cr);

        // Linear burst running off the end of memory.
        drive(1'b0, 32'(1021 * 4), 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
        m0 = n_men;
        sample();
        advance();
        a0 = n_ack;
        e0 = n_err;
        for (int b = 0; b < 3; b++) begin
            drive(1'b0, 32'((1021 + b) * 4), 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
            push_rd(1021 + b);
            sample();
            advance();
        end
        drive(1'b0, 32'(1024 * 4), 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
        sb.push_back('{err: 1'b1, dat: 32'd0});
        sample();
        check("eom_err", 32'(wbs_err_o), 32'd1);
        check("eom_no_ack", 32'(wbs_ack_o), 32'd0);
        advance();
        bus_idle();
        sample();
        check("eom_err_once", 32'(wbs_err_o), 32'd0);
        check("eom_ack_cnt", 32'(n_ack - a0), 32'd3);
        check("eom_err_cnt", 32'(n_err - e0), 32'd1);
        check("eom_men_cnt", 32'(n_men - m0), 32'd3);
        check("eom_sb_left", 32'(sb.size()), 32'd0);
        $display("txn linear burst at 1021: acks=%0d errs=%0d", n_ack - a0, n_err - e0);
        advance();

        // Burst aborted by strobe drop after 3 beats, then a classic read.
        drive(1'b0, 32'h20, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
        sample();
        advance();
        a0 = n_ack;
        for (int b = 0; b < 3; b++) begin
            drive(1'b0, 32'((8 + b) * 4), 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
            push_rd(8 + b);
            sample();
            advance();
        end
        wbs_stb_i = 1'b0;
        sample();
        check("ab_no_ack", 32'(wbs_ack_o), 32'd0);
        check("ab_ack_cnt", 32'(n_ack - a0), 32'd3);
        advance();
        $display("txn aborted burst: acks=%0d", n_ack - a0);
        cr = '{1'b0, 32'h50, 32'h0, 4'hF, CTI_CLASSIC, pat(20)};
        classic(cr);

        // Address mismatch mid-burst: no ack, then re-served as a fresh access.
        drive(1'b0, 32'h40, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
        sample();
        advance();
        push_rd(16);
        sample();
        check("mm_first_ack", 32'(wbs_ack_o), 32'd1);
        advance();
        drive(1'b0, 32'(40 * 4), 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        sample();
        check("mm_no_ack", 32'(wbs_ack_o), 32'd0);
        check("mm_no_en", 32'(mem_en_o), 32'd0);
        advance();
        push_rd(40);
        sample();
        check("mm_fresh_en", 32'(mem_en_o), 32'd1);
        check("mm_fresh_adr", 32'(mem_adr_o), 32'd40);
        advance();
        sample();
        check("mm_fresh_ack", 32'(wbs_ack_o), 32'd1);
        advance();
        bus_idle();
        check("mm_sb_left", 32'(sb.size()), 32'd0);
        $display("txn mismatch burst then fresh read of word 40");

        // Reset pulsed in the middle of a wrap4 burst.
        drive(1'b0, 32'h30, 32'h0, 4'hF, CTI_INCR, BTE_WRAP4);
        sample();
        advance();
        push_rd(12);
        sample();
        check("rs_beat0", 32'(wbs_ack_o), 32'd1);
        advance();
        drive(1'b0, 32'(13 * 4), 32'h0, 4'hF, CTI_INCR, BTE_WRAP4);
        #2;
        check("rs_pre_ack", 32'(wbs_ack_o), 32'd1);
        check("rs_pre_en", 32'(mem_en_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs_ack", 32'(wbs_ack_o), 32'd0);
        check("rs_err", 32'(wbs_err_o), 32'd0);
        check("rs_en", 32'(mem_en_o), 32'd0);
        check("rs_dat", wbs_dat_o, 32'd0);
        advance();
        bus_idle();
        advance();
        rst_n = 1'b1;
        check("rs_sb_left", 32'(sb.size()), 32'd0);
        $display("txn reset during wrap4 burst");
        cr = '{1'b0, 32'(13 * 4), 32'h0, 4'hF, CTI_CLASSIC, pat(13)};
        classic(cr);

        advance();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
